// File: rtl/hdc_pkg.sv
// Shared definitions for the hyperdimensional classifier blocks.
// Holds default sizing, the distance-width helper and the classifier FSM states.
package hdc_pkg;

    localparam int DIMENSIONS_DEF  = 10000;
    localparam int CHUNK_WIDTH_DEF = 500;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } hamming_state_t;

    function automatic int dist_width(input int dim);
        return $clog2(dim + 1);
    endfunction

endpackage

// File: rtl/hamming_classifier_hf_if.sv
// Query/result bundle between the bundler-side producer and the Hamming classifier.
// The producer drives the query and class prototypes; the classifier returns the result.
interface hamming_classifier_hf_if
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = DIMENSIONS_DEF,
    parameter int NUM_CLASSES = 2
);
    localparam int DIST_W = dist_width(DIMENSIONS);
    localparam int CLS_W  = $clog2(NUM_CLASSES);

    logic                                    en;
    logic [DIMENSIONS-1:0]                   hv_in;
    logic [NUM_CLASSES-1:0][DIMENSIONS-1:0]  class_hv;
    logic                                    busy;
    logic                                    out;
    logic [CLS_W-1:0]                        class_out;
    logic [DIST_W-1:0]                       dist_out;

    modport master (
        output en, hv_in, class_hv,
        input  busy, out, class_out, dist_out
    );

    modport slave (
        input  en, hv_in, class_hv,
        output busy, out, class_out, dist_out
    );

endinterface

// File: rtl/hv_chunk_popcount.sv
// Combinational XOR + popcount of two equal-width hypervector slices.
// Mask bits at 0 exclude the corresponding positions from the count.
module hv_chunk_popcount #(
    parameter int CHUNK_WIDTH = 500
) (
    input  logic [CHUNK_WIDTH-1:0]           i_a,
    input  logic [CHUNK_WIDTH-1:0]           i_b,
    input  logic [CHUNK_WIDTH-1:0]           i_mask,
    output logic [$clog2(CHUNK_WIDTH+1)-1:0] o_count
);
    localparam int CNT_W = $clog2(CHUNK_WIDTH + 1);

    logic [CHUNK_WIDTH-1:0] w_diff;

    always_comb begin
        w_diff  = (i_a ^ i_b) & i_mask;
        o_count = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            o_count = o_count + CNT_W'(w_diff[i]);
        end
    end

endmodule

// File: rtl/hamming_classifier_hf.sv
// Associative-memory stage: nearest class hypervector by Hamming distance,
// accumulated one CHUNK_WIDTH slice per cycle.
//
//   state | meaning
//   IDLE  | waiting for en; accepting latches the query and clears accumulators
//   ACCUM | one slice per edge added into every class accumulator
//   DONE  | argmin registered onto class_out/dist_out, out pulses, back to IDLE
module hamming_classifier_hf
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = DIMENSIONS_DEF,
    parameter int NUM_CLASSES = 2,
    parameter int CHUNK_WIDTH = CHUNK_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   nrst,
    hamming_classifier_hf_if.slave bus
);
    localparam int NUM_CHUNKS = (DIMENSIONS + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int DIST_W     = dist_width(DIMENSIONS);
    localparam int CLS_W      = $clog2(NUM_CLASSES);
    localparam int CNT_W      = $clog2(CHUNK_WIDTH + 1);
    localparam int K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int LAST_BITS  = DIMENSIONS - (NUM_CHUNKS - 1) * CHUNK_WIDTH;

    localparam logic [K_W-1:0]         K_LAST    = K_W'(NUM_CHUNKS - 1);
    localparam logic [CHUNK_WIDTH-1:0] LAST_MASK =
        {CHUNK_WIDTH{1'b1}} >> (CHUNK_WIDTH - LAST_BITS);

    hamming_state_t r_state;
    hamming_state_t w_next;

    logic [DIMENSIONS-1:0] r_q;
    logic [K_W-1:0]        r_k;
    logic [DIST_W-1:0]     r_acc [NUM_CLASSES];
    logic                  r_busy;
    logic                  r_out;
    logic [CLS_W-1:0]      r_class;
    logic [DIST_W-1:0]     r_dist;

    logic                                    w_last;
    logic [CHUNK_WIDTH-1:0]                  w_mask;
    logic [PAD_W-1:0]                        w_q_pad;
    logic [NUM_CLASSES-1:0][PAD_W-1:0]       w_cls_pad;
    logic [CHUNK_WIDTH-1:0]                  w_q_chunk;
    logic [NUM_CLASSES-1:0][CHUNK_WIDTH-1:0] w_cls_chunk;
    logic [NUM_CLASSES-1:0][CNT_W-1:0]       w_cnt;
    logic [CLS_W-1:0]                        w_best;
    logic [DIST_W-1:0]                       w_best_dist;

    // Vectors are zero-padded to a whole number of slices; the mask also
    // drops the pad so the last slice only counts bits below DIMENSIONS.
    always_comb begin
        w_last    = (r_k == K_LAST);
        w_mask    = w_last ? LAST_MASK : '1;
        w_q_pad   = '0;
        w_q_pad[DIMENSIONS-1:0] = r_q;
        w_q_chunk = w_q_pad[int'(r_k) * CHUNK_WIDTH +: CHUNK_WIDTH];
        w_cls_pad = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            w_cls_pad[c][DIMENSIONS-1:0] = bus.class_hv[c];
            w_cls_chunk[c] = w_cls_pad[c][int'(r_k) * CHUNK_WIDTH +: CHUNK_WIDTH];
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pc
        hv_chunk_popcount #(
            .CHUNK_WIDTH (CHUNK_WIDTH)
        ) u_pc (
            .i_a     (w_q_chunk),
            .i_b     (w_cls_chunk[g]),
            .i_mask  (w_mask),
            .o_count (w_cnt[g])
        );
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best      = '0;
        w_best_dist = r_acc[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (r_acc[c] < w_best_dist) begin
                w_best      = CLS_W'(c);
                w_best_dist = r_acc[c];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.en) w_next = ACCUM;
            ACCUM:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_out   <= 1'b0;
            r_class <= '0;
            r_dist  <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
        end else begin
            r_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        r_q    <= bus.hv_in;
                        r_k    <= '0;
                        r_busy <= 1'b1;
                        for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
                    end
                end
                ACCUM: begin
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        r_acc[c] <= r_acc[c] + DIST_W'(w_cnt[c]);
                    end
                    if (!w_last) r_k <= r_k + K_W'(1);
                end
                DONE: begin
                    r_out   <= 1'b1;
                    r_class <= w_best;
                    r_dist  <= w_best_dist;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out       = r_out;
    assign bus.class_out = r_class;
    assign bus.dist_out  = r_dist;

endmodule

// File: tb/tb_hamming_classifier_hf.sv
// Bench for hamming_classifier_hf: default 10000-bit config and a 5-bit partial-slice config,
// compared against a whole-vector popcount/argmin reference model.
module tb_hamming_classifier_hf;

    localparam int DA  = 10000;
    localparam int CWA = 500;
    localparam int NCA = 20;
    localparam int DB  = 5;
    localparam int CWB = 2;
    localparam int NCB = 3;

    logic clk;
    logic nrst_a;
    logic nrst_b;
    int   n_pass  = 0;
    int   n_total = 0;

    hamming_classifier_hf_if #(.DIMENSIONS(DA), .NUM_CLASSES(2)) bus_a ();
    hamming_classifier_hf_if #(.DIMENSIONS(DB), .NUM_CLASSES(2)) bus_b ();

    hamming_classifier_hf #(.DIMENSIONS(DA), .NUM_CLASSES(2), .CHUNK_WIDTH(CWA)) dut_a (
        .clk  (clk),
        .nrst (nrst_a),
        .bus  (bus_a)
    );

    hamming_classifier_hf #(.DIMENSIONS(DB), .NUM_CLASSES(2), .CHUNK_WIDTH(CWB)) dut_b (
        .clk  (clk),
        .nrst (nrst_b),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width distance to every class, first minimum wins.
    function automatic void model_a(input logic [DA-1:0] q, input logic [1:0][DA-1:0] cls,
                                    output int bc, output int bd);
        bc = 0;
        bd = DA + 1;
        for (int c = 0; c < 2; c++) begin
            int d;
            d = $countones(q ^ cls[c]);
            if (d < bd) begin bd = d; bc = c; end
        end
    endfunction

    function automatic void model_b(input logic [DB-1:0] q, input logic [1:0][DB-1:0] cls,
                                    output int bc, output int bd);
        bc = 0;
        bd = DB + 1;
        for (int c = 0; c < 2; c++) begin
            int d;
            d = $countones(q ^ cls[c]);
            if (d < bd) begin bd = d; bc = c; end
        end
    endfunction

    function automatic logic [DA-1:0] rand_a(input int pct);
        logic [DA-1:0] v;
        for (int i = 0; i < DA; i++) v[i] = ($urandom_range(99, 0) < pct);
        return v;
    endfunction

    function automatic logic [DA-1:0] ones_a(input int n);
        logic [DA-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic run_a(input logic [DA-1:0] q, input string tag);
        int  ec, ed, lat;
        bit  busy_ok;
        model_a(q, bus_a.class_hv, ec, ed);
        bus_a.hv_in = q;
        bus_a.en    = 1'b1;
        @(posedge clk); #1;
        bus_a.en    = 1'b0;
        bus_a.hv_in = ~q;
        lat = 0;
        busy_ok = 1'b1;
        while (bus_a.out !== 1'b1 && lat < NCA + 10) begin
            if (bus_a.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat == NCA + 1) n_pass++;
        else $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, NCA + 1);
        n_total++;
        if (busy_ok && bus_a.busy === 1'b0) n_pass++;
        else $display("FAIL %s busy window: busy_ok=%0d busy_at_out=%b, expected 1/0", tag, busy_ok, bus_a.busy);
        n_total++;
        if (bus_a.class_out === 1'(ec) && bus_a.dist_out === 14'(ed)) n_pass++;
        else $display("FAIL %s result: got class %0d dist %0d, expected class %0d dist %0d",
                      tag, bus_a.class_out, bus_a.dist_out, ec, ed);
        @(posedge clk); #1;
        n_total++;
        if (bus_a.out === 1'b0 && bus_a.class_out === 1'(ec) && bus_a.dist_out === 14'(ed)) n_pass++;
        else $display("FAIL %s hold: got out %b class %0d dist %0d, expected 0/%0d/%0d",
                      tag, bus_a.out, bus_a.class_out, bus_a.dist_out, ec, ed);
    endtask

    task automatic run_b(input logic [DB-1:0] q, input string tag);
        int ec, ed, lat;
        model_b(q, bus_b.class_hv, ec, ed);
        bus_b.hv_in = q;
        bus_b.en    = 1'b1;
        @(posedge clk); #1;
        bus_b.en    = 1'b0;
        bus_b.hv_in = ~q;
        lat = 0;
        while (bus_b.out !== 1'b1 && lat < NCB + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat == NCB + 1) n_pass++;
        else $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, NCB + 1);
        n_total++;
        if (bus_b.class_out === 1'(ec) && bus_b.dist_out === 3'(ed) && bus_b.busy === 1'b0) n_pass++;
        else $display("FAIL %s result: got class %0d dist %0d busy %b, expected class %0d dist %0d busy 0",
                      tag, bus_b.class_out, bus_b.dist_out, bus_b.busy, ec, ed);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        nrst_a = 1'b0;
        nrst_b = 1'b0;
        bus_a.en = 1'b1;
        bus_b.en = 1'b1;
        bus_a.hv_in = rand_a(50);
        bus_b.hv_in = 5'($urandom);
        bus_a.class_hv = '0;
        bus_b.class_hv = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus_a.busy, bus_a.out} === 2'b00) n_pass++;
        else $display("FAIL reset_a_flags: got busy %b out %b, expected 0 0", bus_a.busy, bus_a.out);
        n_total++;
        if (bus_a.class_out === 1'b0 && bus_a.dist_out === 14'd0) n_pass++;
        else $display("FAIL reset_a_result: got class %0d dist %0d, expected 0 0", bus_a.class_out, bus_a.dist_out);
        n_total++;
        if ({bus_b.busy, bus_b.out, bus_b.class_out, bus_b.dist_out} === 6'd0) n_pass++;
        else $display("FAIL reset_b: got busy %b out %b class %0d dist %0d, expected all 0",
                      bus_b.busy, bus_b.out, bus_b.class_out, bus_b.dist_out);
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        nrst_a = 1'b1;
        nrst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({bus_a.busy, bus_a.out, bus_a.class_out, bus_a.dist_out, bus_b.busy, bus_b.out} === 19'd0) n_pass++;
        else $display("FAIL reset_release: got a busy %b out %b dist %0d, b busy %b out %b, expected all 0",
                      bus_a.busy, bus_a.out, bus_a.dist_out, bus_b.busy, bus_b.out);
    endtask

    task automatic test_default_directed();
        bus_a.class_hv[0] = '0;
        bus_a.class_hv[1] = '1;
        run_a(ones_a(3000), "ones3000");
        n_total++;
        if (bus_a.class_out === 1'b0 && bus_a.dist_out === 14'd3000) n_pass++;
        else $display("FAIL ones3000_const: got class %0d dist %0d, expected 0 3000", bus_a.class_out, bus_a.dist_out);
        run_a(ones_a(7001), "ones7001");
        n_total++;
        if (bus_a.class_out === 1'b1 && bus_a.dist_out === 14'd2999) n_pass++;
        else $display("FAIL ones7001_const: got class %0d dist %0d, expected 1 2999", bus_a.class_out, bus_a.dist_out);
        run_a(ones_a(5000), "tie5000");
        n_total++;
        if (bus_a.class_out === 1'b0 && bus_a.dist_out === 14'd5000) n_pass++;
        else $display("FAIL tie5000_const: got class %0d dist %0d, expected 0 5000", bus_a.class_out, bus_a.dist_out);
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 3; i++) begin
            bus_a.class_hv[0] = rand_a(30 + 20 * i);
            bus_a.class_hv[1] = rand_a(70 - 20 * i);
            run_a(rand_a($urandom_range(90, 10)), "rand_a");
        end
    endtask

    task automatic test_partial_b();
        bus_b.class_hv[0] = 5'b11101;
        bus_b.class_hv[1] = 5'b00010;
        run_b(5'b10101, "part_10101");
        n_total++;
        if (bus_b.class_out === 1'b0 && bus_b.dist_out === 3'd1) n_pass++;
        else $display("FAIL part_10101_const: got class %0d dist %0d, expected 0 1", bus_b.class_out, bus_b.dist_out);
        run_b(5'b00010, "part_00010");
        n_total++;
        if (bus_b.class_out === 1'b1 && bus_b.dist_out === 3'd0) n_pass++;
        else $display("FAIL part_00010_const: got class %0d dist %0d, expected 1 0", bus_b.class_out, bus_b.dist_out);
        // 11011 differs from class0 in 2 bits and from class1 in 3 bits.
        run_b(5'b11011, "part_11011");
        n_total++;
        if (bus_b.class_out === 1'b0 && bus_b.dist_out === 3'd2) n_pass++;
        else $display("FAIL part_11011_const: got class %0d dist %0d, expected 0 2", bus_b.class_out, bus_b.dist_out);
        for (int i = 0; i < 6; i++) begin
            bus_b.class_hv[0] = 5'($urandom);
            bus_b.class_hv[1] = 5'($urandom);
            run_b(5'($urandom), "rand_b");
        end
    endtask

    task automatic test_ignore_en_b();
        int lat;
        bit extra;
        bus_b.class_hv[0] = 5'b11101;
        bus_b.class_hv[1] = 5'b00010;
        bus_b.hv_in = 5'b00010;
        bus_b.en    = 1'b1;
        @(posedge clk); #1;
        bus_b.en = 1'b0;
        lat = 0;
        while (bus_b.out !== 1'b1 && lat < NCB + 10) begin
            bus_b.en    = (lat == 1);
            bus_b.hv_in = 5'b11101;
            @(posedge clk); #1;
            lat++;
        end
        bus_b.en = 1'b0;
        n_total++;
        if (lat == NCB + 1 && bus_b.class_out === 1'b1 && bus_b.dist_out === 3'd0) n_pass++;
        else $display("FAIL ignore_en_first: got lat %0d class %0d dist %0d, expected 4 1 0",
                      lat, bus_b.class_out, bus_b.dist_out);
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus_b.out !== 1'b0 || bus_b.busy !== 1'b0) extra = 1'b1;
        end
        n_total++;
        if (!extra) n_pass++;
        else $display("FAIL ignore_en_extra: got a second result or busy, expected none");
    endtask

    task automatic test_back_to_back_b();
        int lat, lat2, ec, ed;
        bus_b.class_hv[0] = 5'b11101;
        bus_b.class_hv[1] = 5'b00010;
        bus_b.hv_in = 5'b10101;
        bus_b.en    = 1'b1;
        @(posedge clk); #1;
        bus_b.en = 1'b0;
        lat = 0;
        while (bus_b.out !== 1'b1 && lat < NCB + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat == NCB + 1 && bus_b.class_out === 1'b0 && bus_b.dist_out === 3'd1) n_pass++;
        else $display("FAIL b2b_first: got lat %0d class %0d dist %0d, expected 4 0 1",
                      lat, bus_b.class_out, bus_b.dist_out);
        bus_b.hv_in = 5'b00011;
        bus_b.en    = 1'b1;
        model_b(5'b00011, bus_b.class_hv, ec, ed);
        @(posedge clk); #1;
        bus_b.en = 1'b0;
        lat2 = 1;
        while (bus_b.out !== 1'b1 && lat2 < NCB + 10) begin
            @(posedge clk); #1;
            lat2++;
        end
        n_total++;
        if (lat2 == NCB + 2) n_pass++;
        else $display("FAIL b2b_spacing: got %0d cycles between results, expected %0d", lat2, NCB + 2);
        n_total++;
        if (bus_b.class_out === 1'(ec) && bus_b.dist_out === 3'(ed)) n_pass++;
        else $display("FAIL b2b_second: got class %0d dist %0d, expected %0d %0d",
                      bus_b.class_out, bus_b.dist_out, ec, ed);
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset_a();
        bit seen;
        bus_a.class_hv[0] = '0;
        bus_a.class_hv[1] = '1;
        bus_a.hv_in = ones_a(1234);
        bus_a.en    = 1'b1;
        @(posedge clk); #1;
        bus_a.en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nrst_a = 1'b0;
        #1;
        n_total++;
        if ({bus_a.busy, bus_a.out, bus_a.class_out, bus_a.dist_out} === 17'd0) n_pass++;
        else $display("FAIL midreset_clear: got busy %b out %b class %0d dist %0d, expected all 0",
                      bus_a.busy, bus_a.out, bus_a.class_out, bus_a.dist_out);
        #4;
        nrst_a = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < NCA + 6; i++) begin
            if (bus_a.out !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.dist_out !== 14'd0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_total++;
        if (!seen) n_pass++;
        else $display("FAIL midreset_abort: got activity after aborted query, expected none");
        run_a(ones_a(8500), "after_reset");
    endtask

    initial begin
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        test_reset();
        test_default_directed();
        test_random_a();
        test_partial_b();
        test_ignore_en_b();
        test_back_to_back_b();
        test_mid_reset_a();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
